// File: rtl/slave_select_pkg.sv
// Shared encodings and default sizing for the SPI slave-select generator.
package slave_select_pkg;

  localparam int DIV_W      = 16;
  localparam int FRAME_BITS = 8;

  localparam logic [1:0] SPI_MODE_RUN  = 2'b00;
  localparam logic [1:0] SPI_MODE_WAIT = 2'b01;
  localparam logic [1:0] SPI_MODE_STOP = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_GAP    = 2'b10
  } state_e;

  // STOP (10/11) never enables; WAIT enables only when the SPI keeps running in wait mode.
  function automatic logic mode_enable(input logic mstr, input logic spiswai,
                                       input logic [1:0] spi_mode);
    return mstr & ((spi_mode == SPI_MODE_RUN) |
                   ((spi_mode == SPI_MODE_WAIT) & ~spiswai));
  endfunction

endpackage

// File: rtl/ss_frame_counter.sv
// Loadable frame-length up-counter; terminal flags the last cycle of a frame.
module ss_frame_counter #(
  parameter int W = 21
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic         inc,
  input  logic [W-1:0] target_in,
  output logic         terminal
);

  logic [W-1:0] count_r;
  logic [W-1:0] target_r;

  // Count and latched frame length; load restarts the count at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r  <= {W{1'b0}};
      target_r <= {W{1'b0}};
    end else if (load) begin
      count_r  <= {W{1'b0}};
      target_r <= target_in;
    end else if (clear) begin
      count_r  <= {W{1'b0}};
    end else if (inc) begin
      count_r  <= count_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r  <= count_r;
    end
  end

  // A zero target never starts a frame, so it must never report terminal either.
  assign terminal = (target_r != {W{1'b0}}) &&
                    (count_r == target_r - {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/slave_select.sv
// SPI-master slave-select frame generator (FSM plus registered ss/tip/receive_data).
// Optional macro SLAVE_SELECT_GAP_EN adds a 2-cycle ss-high guard after each frame.
module slave_select #(
  parameter int DIV_W      = slave_select_pkg::DIV_W,
  parameter int FRAME_BITS = slave_select_pkg::FRAME_BITS
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             mstr,
  input  logic             spiswai,
  input  logic [1:0]       spi_mode,
  input  logic             send_data,
  input  logic [DIV_W-1:0] BaudRateDivisor,
  output logic             tip,
  output logic             ss,
  output logic             receive_data
);

  import slave_select_pkg::*;

  localparam int TW = DIV_W + 5;

`ifdef SLAVE_SELECT_GAP_EN
  localparam state_e EXIT_STATE = ST_GAP;
`else
  localparam state_e EXIT_STATE = ST_IDLE;
`endif

  state_e        state_r;
  state_e        next_state_s;
  logic          ss_r;
  logic          tip_r;
  logic          rx_r;
  logic          enable_s;
  logic          start_s;
  logic          load_s;
  logic          clear_s;
  logic          inc_s;
  logic          done_s;
  logic          terminal_s;
  logic [TW-1:0] target_s;

  assign enable_s = mode_enable(mstr, spiswai, spi_mode);
  assign start_s  = send_data & enable_s & (BaudRateDivisor != {DIV_W{1'b0}});
  assign target_s = TW'(BaudRateDivisor) * TW'(2 * FRAME_BITS);

  ss_frame_counter #(.W(TW)) u_counter (
    .clk       (PCLK),
    .rst       (PRESETn),
    .load      (load_s),
    .clear     (clear_s),
    .inc       (inc_s),
    .target_in (target_s),
    .terminal  (terminal_s)
  );

`ifdef SLAVE_SELECT_GAP_EN
  logic gap_cnt_r;

  // Guard-cycle counter: toggles once per GAP cycle, so GAP lasts exactly two cycles.
  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      gap_cnt_r <= 1'b0;
    end else if (state_r == ST_GAP) begin
      gap_cnt_r <= ~gap_cnt_r;
    end else begin
      gap_cnt_r <= 1'b0;
    end
  end
`endif

  // Next-state and counter control; abort takes priority over completion.
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    clear_s      = 1'b0;
    inc_s        = 1'b0;
    done_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          next_state_s = ST_ACTIVE;
          load_s       = 1'b1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (!enable_s) begin
          next_state_s = EXIT_STATE;
          clear_s      = 1'b1;
        end else if (terminal_s) begin
          next_state_s = EXIT_STATE;
          clear_s      = 1'b1;
          done_s       = 1'b1;
        end else begin
          next_state_s = ST_ACTIVE;
          inc_s        = 1'b1;
        end
      end
      ST_GAP: begin
`ifdef SLAVE_SELECT_GAP_EN
        if (gap_cnt_r) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_GAP;
        end
`else
        next_state_s = ST_IDLE;
`endif
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; outputs are decoded from the next state so they align with it.
  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      state_r <= ST_IDLE;
      ss_r    <= 1'b1;
      tip_r   <= 1'b0;
      rx_r    <= 1'b0;
    end else begin
      state_r <= next_state_s;
      ss_r    <= (next_state_s != ST_ACTIVE);
      tip_r   <= (next_state_s == ST_ACTIVE);
      rx_r    <= done_s;
    end
  end

  assign ss           = ss_r;
  assign tip          = tip_r;
  assign receive_data = rx_r;

endmodule

// File: tb/tb_slave_select.sv
// Self-checking bench for slave_select: expected frame results are queued at stimulus time.
module tb_slave_select;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        mstr;
  logic        spiswai;
  logic [1:0]  spi_mode;
  logic        send_data;
  logic [15:0] BaudRateDivisor;
  logic        tip;
  logic        ss;
  logic        receive_data;

  int n_cmp = 0;
  int n_err = 0;
  int exp_len_q[$];
  bit exp_rx_q[$];

  slave_select dut (
    .PCLK            (PCLK),
    .PRESETn         (PRESETn),
    .mstr            (mstr),
    .spiswai         (spiswai),
    .spi_mode        (spi_mode),
    .send_data       (send_data),
    .BaudRateDivisor (BaudRateDivisor),
    .tip             (tip),
    .ss              (ss),
    .receive_data    (receive_data)
  );

  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic expect_frame(input int len, input bit rx);
    exp_len_q.push_back(len);
    exp_rx_q.push_back(rx);
  endtask

  task automatic start_frame(input logic [15:0] div);
    BaudRateDivisor = div;
    send_data = 1'b1;
    tick();
    send_data = 1'b0;
  endtask

  // abort_kind: 1 = switch to STOP mode, 2 = assert reset
  task automatic measure_frame(input int resend_at, input int abort_at,
                               input int abort_kind, input bit send_after);
    int exp_len;
    bit exp_rx;
    int low;
    int bad;
    exp_len = exp_len_q.pop_front();
    exp_rx  = exp_rx_q.pop_front();
    low = 0;
    bad = 0;
    while (ss === 1'b0 && low < 5000) begin
      if (tip !== 1'b1 || receive_data !== 1'b0) bad++;
      low++;
      send_data = (low == resend_at);
      if (low == resend_at) BaudRateDivisor = 16'd3;
      if (low == abort_at) begin
        if (abort_kind == 1) spi_mode = 2'b10;
        else PRESETn = 1'b1;
      end
      tick();
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL active_outputs: %0d cycles with tip!=1 or receive_data!=0, want 0", bad);
    end
    n_cmp++;
    if (low != exp_len) begin
      n_err++;
      $display("FAIL ss_low_len: got %0d cycles, want %0d", low, exp_len);
    end
    n_cmp++;
    if (tip !== 1'b0 || ss !== 1'b1) begin
      n_err++;
      $display("FAIL end_idle: got ss=%b tip=%b, want ss=1 tip=0", ss, tip);
    end
    n_cmp++;
    if (receive_data !== exp_rx) begin
      n_err++;
      $display("FAIL rx_at_end: got %b, want %b", receive_data, exp_rx);
    end
    PRESETn   = 1'b0;
    spi_mode  = 2'b00;
    send_data = send_after;
    tick();
    send_data = 1'b0;
    n_cmp++;
    if (receive_data !== 1'b0) begin
      n_err++;
      $display("FAIL rx_one_cycle: got %b, want 0", receive_data);
    end
  endtask

  task automatic test_reset();
    PRESETn = 1'b1;
    tick();
    tick();
    PRESETn = 1'b0;
    tick();
    n_cmp++;
    if ({ss, tip, receive_data} !== 3'b100) begin
      n_err++;
      $display("FAIL reset_values: got ss,tip,rx=%b, want 100", {ss, tip, receive_data});
    end
  endtask

  task automatic test_frame();
    expect_frame(160, 1'b1);
    start_frame(16'd10);
    measure_frame(-1, -1, 0, 1'b0);
  endtask

  task automatic test_resend_ignored();
    expect_frame(160, 1'b1);
    start_frame(16'd10);
    measure_frame(20, -1, 0, 1'b0);
  endtask

  task automatic test_disabled();
    logic [20:0] cfg [5];
    cfg[0] = {1'b0, 2'b00, 1'b0, 16'd10, 1'b0};
    cfg[1] = {1'b1, 2'b10, 1'b0, 16'd10, 1'b0};
    cfg[2] = {1'b1, 2'b01, 1'b1, 16'd10, 1'b0};
    cfg[3] = {1'b1, 2'b00, 1'b0, 16'd0,  1'b0};
    cfg[4] = {1'b1, 2'b11, 1'b0, 16'd2,  1'b0};
    for (int i = 0; i < 5; i++) begin
      int hits;
      hits = 0;
      {mstr, spi_mode, spiswai, BaudRateDivisor} = cfg[i][20:1];
      send_data = 1'b1;
      tick();
      send_data = 1'b0;
      for (int c = 0; c < 20; c++) begin
        if (ss !== 1'b1 || tip !== 1'b0 || receive_data !== 1'b0) hits++;
        tick();
      end
      n_cmp++;
      if (hits != 0) begin
        n_err++;
        $display("FAIL disabled_%0d: %0d active cycles, want 0", i, hits);
      end
    end
    mstr = 1'b1;
    spi_mode = 2'b00;
    spiswai = 1'b0;
  endtask

  task automatic test_wait_mode();
    spi_mode = 2'b01;
    spiswai  = 1'b0;
    expect_frame(32, 1'b1);
    start_frame(16'd2);
    spi_mode = 2'b01;
    measure_frame(-1, -1, 0, 1'b0);
  endtask

  task automatic test_abort_stop();
    expect_frame(50, 1'b0);
    start_frame(16'd10);
    measure_frame(-1, 50, 1, 1'b0);
  endtask

  task automatic test_abort_reset();
    expect_frame(50, 1'b0);
    start_frame(16'd10);
    measure_frame(-1, 50, 2, 1'b0);
  endtask

  task automatic test_div_one();
    expect_frame(16, 1'b1);
    start_frame(16'd1);
    measure_frame(-1, -1, 0, 1'b0);
  endtask

`ifdef SLAVE_SELECT_GAP_EN
  task automatic test_gap();
    expect_frame(16, 1'b1);
    start_frame(16'd1);
    measure_frame(-1, -1, 0, 1'b1);
    n_cmp++;
    if (ss !== 1'b1 || tip !== 1'b0) begin
      n_err++;
      $display("FAIL gap_ignore: got ss=%b tip=%b, want ss=1 tip=0", ss, tip);
    end
    tick();
    expect_frame(16, 1'b1);
    start_frame(16'd1);
    measure_frame(-1, -1, 0, 1'b0);
  endtask
`else
  task automatic test_back_to_back();
    BaudRateDivisor = 16'd1;
    expect_frame(16, 1'b1);
    start_frame(16'd1);
    expect_frame(16, 1'b1);
    measure_frame(-1, -1, 0, 1'b1);
    n_cmp++;
    if (ss !== 1'b0 || tip !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_start: got ss=%b tip=%b, want ss=0 tip=1", ss, tip);
    end
    measure_frame(-1, -1, 0, 1'b0);
  endtask
`endif

  initial begin
    PRESETn         = 1'b1;
    mstr            = 1'b1;
    spiswai         = 1'b0;
    spi_mode        = 2'b00;
    send_data       = 1'b0;
    BaudRateDivisor = 16'd10;
    test_reset();
    test_frame();
    test_resend_ignored();
    test_disabled();
    test_wait_mode();
    test_abort_stop();
    test_abort_reset();
    test_div_one();
`ifdef SLAVE_SELECT_GAP_EN
    test_gap();
`else
    test_back_to_back();
`endif
    n_cmp++;
    if (exp_len_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_len_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
